// File: rtl/xga_timing_gen_if.sv
// rtl/xga_timing_gen_if.sv - raster timing bundle between timing source and background generators
interface xga_timing_gen_if;
    logic        pix_en;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        video_active;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;
    logic [9:0]  frame_cnt;

    modport master (
        input  pix_en,
        output pix_x, pix_y, video_active, hsync, vsync, line_start, frame_start, frame_cnt
    );

    modport slave (
        output pix_en,
        input  pix_x, pix_y, video_active, hsync, vsync, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/xga_timing_gen.sv
// rtl/xga_timing_gen.sv - XGA raster timing source with sync, active flag and frame counter
// Every output is a flop loaded with the decode of the next raster position, so pix_x/pix_y track h/v exactly.
module xga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    xga_timing_gen_if.master  vid
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_FP_START   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_BP_START   = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FPORCH,
        PH_SYNC,
        PH_BPORCH
    } phase_e;

    function automatic phase_e decode_phase(
        input logic [10:0] cnt,
        input logic [10:0] fp_start,
        input logic [10:0] sync_start,
        input logic [10:0] bp_start
    );
        if (cnt < fp_start)        return PH_ACTIVE;
        else if (cnt < sync_start) return PH_FPORCH;
        else if (cnt < bp_start)   return PH_SYNC;
        else                       return PH_BPORCH;
    endfunction

    logic [10:0] h_q, h_d, v_q, v_d;
    logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        video_active_q, video_active_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [9:0]  frame_cnt_q, frame_cnt_d;

    logic [10:0] h_nxt, v_nxt;
    phase_e      h_phase, v_phase;

    always_comb begin
        h_nxt = (h_q == H_LAST) ? 11'd0 : h_q + 11'd1;
        v_nxt = v_q;
        if (h_q == H_LAST) begin
            v_nxt = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
        end
        h_phase = decode_phase(h_nxt, H_FP_START, H_SYNC_START, H_BP_START);
        v_phase = decode_phase(v_nxt, V_FP_START, V_SYNC_START, V_BP_START);

        h_d            = h_q;
        v_d            = v_q;
        pix_x_d        = pix_x_q;
        pix_y_d        = pix_y_q;
        video_active_d = video_active_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;
        frame_cnt_d    = frame_cnt_q;
        // Pulses are never held: any clk without a pixel slot drops them.
        line_start_d   = 1'b0;
        frame_start_d  = 1'b0;

        if (vid.pix_en) begin
            h_d            = h_nxt;
            v_d            = v_nxt;
            pix_x_d        = h_nxt;
            pix_y_d        = v_nxt;
            video_active_d = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            hsync_d        = (h_phase == PH_SYNC) ? H_POL : ~H_POL;
            // v only changes when h wraps to 0, so vsync edges land on line boundaries.
            vsync_d        = (v_phase == PH_SYNC) ? V_POL : ~V_POL;
            line_start_d   = (h_nxt == 11'd0);
            frame_start_d  = (h_nxt == 11'd0) && (v_nxt == 11'd0);
            if ((h_nxt == 11'd0) && (v_nxt == 11'd0)) begin
                frame_cnt_d = frame_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q            <= H_LAST;
            v_q            <= V_LAST;
            pix_x_q        <= 11'd0;
            pix_y_q        <= 11'd0;
            video_active_q <= 1'b0;
            hsync_q        <= ~H_POL;
            vsync_q        <= ~V_POL;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_cnt_q    <= 10'h3FF;
        end else begin
            h_q            <= h_d;
            v_q            <= v_d;
            pix_x_q        <= pix_x_d;
            pix_y_q        <= pix_y_d;
            video_active_q <= video_active_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign vid.pix_x        = pix_x_q;
    assign vid.pix_y        = pix_y_q;
    assign vid.video_active = video_active_q;
    assign vid.hsync        = hsync_q;
    assign vid.vsync        = vsync_q;
    assign vid.line_start   = line_start_q;
    assign vid.frame_start  = frame_start_q;
    assign vid.frame_cnt    = frame_cnt_q;

endmodule
